flush_station: RTL

- Receiving end of the scanner flush handshake.
- Watches the combined rdy_flush from the scanner pair and issues a single-cycle flush command.
- Accepts exactly the advertised number of data bytes from the flushing scanner over a valid/ready link and buffers them in an internal FIFO for a downstream consumer.
- Reports progress, completion and timeout errors for display/status logic.

---
 rtl/flush_station.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/flush_station.sv
// flush_station: receives a scanner flush, issues a one-cycle flush command,
// collects the advertised number of words into a FWFT FIFO and reports status.
module flush_station #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdy_flush,
  input  logic [7:0]        mem_used,
  output logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [7:0]        xfer_count,
  output logic              done,
  output logic              err_timeout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              rdy_prev_q;
  logic [7:0]        target_q, target_d;
  logic [7:0]        count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop;

  // FIFO status and handshakes; data_ready depends on registered state only
  always_comb begin
    fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
    fifo_empty = (occ_q == '0);
    data_ready = (state_q == S_RECV) && !fifo_full;
    push       = data_ready && data_valid;
    pop        = !fifo_empty && out_ready;
    out_valid  = !fifo_empty;
    out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end

  // Transfer sequencing: trigger, flush request, receive with idle timeout, drain
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    timer_d  = timer_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (rdy_flush && !rdy_prev_q) begin
          state_d  = S_REQ;
          target_d = mem_used;
          count_d  = '0;
          timer_d  = '0;
          err_d    = 1'b0;
        end
      end
      S_REQ:   state_d = (target_q == '0) ? S_DRAIN : S_RECV;
      S_RECV: begin
        if (push) begin
          count_d = count_q + 8'd1;
          timer_d = '0;
          if (count_q + 8'd1 == target_q) state_d = S_DRAIN;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    flush_d = (state_d == S_REQ);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!push && pop) occ_d = occ_q - OCC_W'(1);
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rdy_prev_q <= 1'b0;
      target_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_prev_q <= rdy_flush;
      target_q   <= target_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign flush       = flush_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign xfer_count  = count_q;
  assign err_timeout = err_q;

endmodule
